// File: rtl/alu_result_tx.sv
// alu_result_tx: snapshots the ALU result and carry flag on request and sends them
// out on one UART line as two back-to-back 8N1 words (result, then carry byte).
`default_nettype none

module alu_result_tx #(
  parameter int SIZEDATA     = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SIZEDATA-1:0] result_i,
  input  logic                carry_i,
  input  logic                send_i,
  output logic                tx_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (SIZEDATA > 1) ? $clog2(SIZEDATA) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZEDATA - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [SIZEDATA-1:0] shift_q, shift_d;
  logic                carry_q, carry_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                word_q, word_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    carry_d = carry_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    word_d  = word_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (send_i) begin
          shift_d = result_i;
          carry_d = carry_i;
          word_d  = 1'b0;
          bit_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (!word_q) begin
            // Second word carries only the flag; it follows with no idle gap.
            shift_d = {{(SIZEDATA-1){1'b0}}, carry_q};
            word_d  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the current state, so they trail the FSM by
  // one cycle; DONE fires on the edge where BUSY drops after a full frame.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_IDLE) && busy_q;
    if (state_q == S_START) begin
      tx_d = 1'b0;
    end else if (state_q == S_DATA) begin
      tx_d = shift_q[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      carry_q <= 1'b0;
      bit_q   <= '0;
      baud_q  <= '0;
      word_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: doc/alu_result_tx.md
# alu_result_tx

Serial result transmitter for the ALU board design: on a send request it snapshots the ALU result and carry flag and shifts them out on a single UART line as a two-byte 8N1 frame. It sits downstream of the ALU, on the output side opposite the switch/button operand loader, replacing LED-only readout with a host-readable stream. Fully synchronous to one clock; no receive path.

## Interface
- SIZEDATA, 8: width of RESULT and of each transmitted data word.
- CLKS_PER_BIT, 868: clock cycles per serial bit (868 = 115200 baud at 100 MHz); must be ≥ 2.
- CLK  input  1  system clock, all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
- RESULT  input  SIZEDATA  ALU result, sampled only at frame start.
- CARRY  input  1  ALU carry flag, sampled together with RESULT.
- SEND  input  1  level request; sampled in IDLE only.
- TX  output  1  serial line, idle high.
- BUSY  output  1  high from the cycle after acceptance until the frame ends.
- DONE  output  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers: shift register (SIZEDATA), snapshot of CARRY, bit counter (0..SIZEDATA-1), baud counter (0..CLKS_PER_BIT-1), word index (0/1).
- IDLE: TX=1, BUSY=0. SEND=1 at an edge: load shift register with RESULT, latch CARRY, word index=0, baud counter=0, go START.
- START: TX=0 for CLKS_PER_BIT cycles, then DATA with bit counter=0.
- DATA: TX=shift register bit 0 (LSB first); each CLKS_PER_BIT cycles shift right by one, increment bit counter; after bit SIZEDATA-1 go STOP.
- STOP: TX=1 for CLKS_PER_BIT cycles. Then: word index 0 → load shift register with {(SIZEDATA-1) zeros, latched CARRY}, word index=1, go START (no idle gap). Word index 1 → go IDLE, DONE=1 for that cycle.
- Word 0 = RESULT, word 1 = carry byte; both are plain SIZEDATA-bit 8N1-style words (start, SIZEDATA data, one stop).
- SEND while BUSY: ignored, not queued. RESULT/CARRY changes during a frame: no effect on the frame in flight.
- All outputs registered; TX never glitches.

## Timing
- Reset values: TX=1, BUSY=0, DONE=0, state IDLE, all counters and shift register 0. Reset mid-frame: TX goes high immediately (asynchronous), frame aborted, no DONE.
- Acceptance: SEND high at edge k in IDLE → TX=0 and BUSY=1 from edge k+1.
- Each bit lasts exactly CLKS_PER_BIT cycles; one word = (SIZEDATA+2)·CLKS_PER_BIT cycles; full frame = 2·(SIZEDATA+2)·CLKS_PER_BIT cycles from edge k+1.
- Frame end edge: BUSY→0, DONE→1 on the same edge; DONE→0 on the next edge.
- SEND held high continuously: next frame accepted on the edge after DONE, so TX stays high for CLKS_PER_BIT+1 cycles between frames (one extra idle cycle, guaranteed).
- Baud counter wrap: counts 0..CLKS_PER_BIT-1, bit advances at terminal count, counter returns to 0.

## Test plan
- Reset: RESET_N low then released, SEND=0 → TX=1, BUSY=0, DONE=0 held for 100 cycles.
- Basic frame, CLKS_PER_BIT=4: RESULT=8'hA5, CARRY=1, SEND one-cycle pulse → TX bits 0,1,0,1,0,0,1,0,1,1 then 0,1,0,0,0,0,0,0,0,1, each 4 cycles; BUSY high 80 cycles; DONE single pulse at cycle 80.
- Busy ignore: start frame with RESULT=8'h3C, CARRY=0; pulse SEND with RESULT=8'hFF at cycle 20 → transmitted bytes 8'h3C, 8'h00 only; one DONE.
- Back-to-back: SEND held high, RESULT=8'h01 → consecutive frames separated by exactly CLKS_PER_BIT+1 high cycles; DONE once per frame.
- Reset mid-frame: assert RESET_N low during DATA of word 0 → TX=1 asynchronously, BUSY=0, no DONE; next SEND with RESULT=8'h81, CARRY=1 yields full correct frame.
- Input snapshot: change RESULT from 8'h55 to 8'hAA one cycle after acceptance → received word 0 = 8'h55.
